// File: rtl/sync_filter_multi.sv
// Multi-channel boundary conditioner. Each channel passes through a flop-chain synchroniser and a debounce filter.
// The filter registers a debounced level, one-cycle rise and fall pulses, and a combined any_change flag.
module sync_filter_multi #(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             any_change
);
    localparam int               CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [WIDTH-1:0] chain [STAGES];
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [WIDTH-1:0] flip;

    assign sync_out = chain[STAGES-1];

    // Pure flop chain with no logic between stages, so metastability stays in stage 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) chain[s] <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments let every stage capture its predecessor's old value, forming a true shift register.
            chain[0] <= async_in;
            for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
        end
    end

    // A channel flips once its disagreement has lasted FILTER_LEN consecutive cycles.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++)
            flip[i] = (sync_out[i] != filt_out[i]) && (cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_out   <= RST_VAL;
            rise_out   <= '0;
            fall_out   <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            filt_out   <= (filt_out & ~flip) | (sync_out & flip);
            rise_out   <= flip & sync_out;
            fall_out   <= flip & ~sync_out;
            any_change <= |flip;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == filt_out[i] || flip[i]) cnt[i] <= '0;
                else                                       cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: a vector table for the WIDTH=4/STAGES=2/FILTER_LEN=3 instance,
// plus a hand-written sequence for a STAGES=3/FILTER_LEN=1/RST_VAL=4'hF instance.
module tb_sync_filter_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, sync_a, filt_a, rise_a, fall_a;
    logic       any_a;
    logic [3:0] b, sync_b, filt_b, rise_b, fall_b;
    logic       any_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] sync;
        logic [3:0] filt;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RST_VAL(4'h0)) dut_a (
        .clk(clk), .rst(rst), .async_in(a), .sync_out(sync_a), .filt_out(filt_a),
        .rise_out(rise_a), .fall_out(fall_a), .any_change(any_a)
    );

    sync_filter_multi #(.WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RST_VAL(4'hF)) dut_b (
        .clk(clk), .rst(rst), .async_in(b), .sync_out(sync_b), .filt_out(filt_b),
        .rise_out(rise_b), .fall_out(fall_b), .any_change(any_b)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] ai, input logic [3:0] s, input logic [3:0] f,
                       input logic [3:0] ri, input logic [3:0] fa, input logic an);
        vec_t v;
        v.rst = r; v.a = ai; v.sync = s; v.filt = f; v.rise = ri; v.fall = fa; v.any = an;
        vecs.push_back(v);
    endtask

    // Inputs change at negedge; outputs are sampled 1 time unit after the following posedge.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        a   = v.a;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("row%0d sync", idx), sync_a, e.sync);
        check($sformatf("row%0d filt", idx), filt_a, e.filt);
        check($sformatf("row%0d rise", idx), rise_a, e.rise);
        check($sformatf("row%0d fall", idx), fall_a, e.fall);
        check($sformatf("row%0d any", idx), {3'b000, any_a}, {3'b000, e.any});
    endtask

    task automatic step_b(input string name, input logic r, input logic [3:0] bi,
                          input logic [3:0] s, input logic [3:0] f, input logic [3:0] fa);
        @(negedge clk);
        rst = r;
        b   = bi;
        @(posedge clk);
        #1;
        check({name, " sync"}, sync_b, s);
        check({name, " filt"}, filt_b, f);
        check({name, " rise"}, rise_b, 4'h0);
        check({name, " fall"}, fall_b, fa);
        check({name, " any"}, {3'b000, any_b}, {3'b000, |fa});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'hF;

        // Reset held with inputs high, then released: filter accepts after 5 edges.
        for (int i = 0; i < 3; i++) add(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        // All channels fall together.
        add(0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // Latency on channel 0.
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        // Two-cycle glitch on channel 1 is rejected.
        add(0, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        // Three-cycle pulse on channel 1 passes, three cycles wide.
        add(0, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h3, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h3, 4'h2, 4'h0, 1);
        add(0, 4'h1, 4'h1, 4'h3, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h3, 4'h0, 4'h0, 0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 1);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        // Settle channel 3 high.
        add(0, 4'h9, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h9, 4'h9, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h9, 4'h9, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h9, 4'h9, 4'h1, 4'h0, 4'h0, 0);
        add(0, 4'h9, 4'h9, 4'h9, 4'h8, 4'h0, 1);
        add(0, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 0);
        // Channel 2 rises while channel 3 falls.
        add(0, 4'h5, 4'h9, 4'h9, 4'h0, 4'h0, 0);
        add(0, 4'h5, 4'h5, 4'h9, 4'h0, 4'h0, 0);
        add(0, 4'h5, 4'h5, 4'h9, 4'h0, 4'h0, 0);
        add(0, 4'h5, 4'h5, 4'h9, 4'h0, 4'h0, 0);
        add(0, 4'h5, 4'h5, 4'h5, 4'h4, 4'h8, 1);
        add(0, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 0);
        // Reset while channel 0 disagrees with its count at 2; the full latency is needed again.
        add(0, 4'h4, 4'h5, 4'h5, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h5, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h5, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h5, 4'h0, 4'h0, 0);
        add(1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 1);
        add(0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 0);
        // A single agreeing cycle restarts the count on channel 1.
        add(0, 4'h6, 4'h4, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h6, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h4, 4'h6, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h4, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h6, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h6, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h6, 4'h4, 4'h0, 4'h0, 0);
        add(0, 4'h6, 4'h6, 4'h6, 4'h2, 4'h0, 1);
        add(0, 4'h6, 4'h6, 4'h6, 4'h0, 4'h0, 0);

        foreach (vecs[i]) apply(i, vecs[i]);

        // Second instance: reset to all ones, no pulse on release, then a 1->0 on channel 0.
        step_b("b_rst0", 1, 4'hF, 4'hF, 4'hF, 4'h0);
        step_b("b_rst1", 1, 4'hF, 4'hF, 4'hF, 4'h0);
        for (int i = 0; i < 4; i++) step_b($sformatf("b_idle%0d", i), 0, 4'hF, 4'hF, 4'hF, 4'h0);
        step_b("b_e1", 0, 4'hE, 4'hF, 4'hF, 4'h0);
        step_b("b_e2", 0, 4'hE, 4'hF, 4'hF, 4'h0);
        step_b("b_e3", 0, 4'hE, 4'hE, 4'hF, 4'h0);
        step_b("b_e4", 0, 4'hE, 4'hE, 4'hE, 4'h1);
        step_b("b_e5", 0, 4'hE, 4'hE, 4'hE, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
